ex_expand: RTL and testbench

//  Parametrised successor of the execute stage in the backtracking search pipeline.

---
 rtl/ex_expand.sv | 172 +++++++++++++++++
 tb/tb_ex_expand.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_expand.sv
// Execute-stage node expander for the backtracking search pipeline: takes one search node
// and emits one child per alphabet symbol (or a hit report), with z<D(i) pruning.
module ex_expand #(
  parameter int IDX_W  = 8,
  parameter int Z_W    = 8,
  parameter int ADDR_W = 12,
  parameter int POS_W  = 5,
  parameter int ALPHA  = 4,
  localparam int SYM_W = $clog2(ALPHA)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode_exact,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [POS_W-1:0]       in_pos,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [IDX_W-1:0]       in_i,
  input  logic [Z_W-1:0]         in_z,
  input  logic [Z_W-1:0]         in_d,
  input  logic [IDX_W-1:0]       in_k,
  input  logic [IDX_W-1:0]       in_l,
  input  logic [SYM_W-1:0]       in_read_sym,
  input  logic [ALPHA*IDX_W-1:0] in_c,
  input  logic [ALPHA*IDX_W-1:0] in_occ_k,
  input  logic [ALPHA*IDX_W-1:0] in_occ_l,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_hit,
  output logic [POS_W-1:0]       out_pos,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [SYM_W-1:0]       out_sym,
  output logic [IDX_W-1:0]       out_i,
  output logic [Z_W-1:0]         out_z,
  output logic [IDX_W-1:0]       out_k,
  output logic [IDX_W-1:0]       out_l,
  output logic [15:0]            prune_cnt
);

  typedef enum logic [1:0] {IDLE, EXPAND, HIT} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t                 state;
  logic [SYM_W-1:0]       b_p0;
  logic                   exact_p0;
  logic                   vld_p1;

  logic [POS_W-1:0]       pos_p0;
  logic [ADDR_W-1:0]      addr_p0;
  logic [IDX_W-1:0]       i_p0;
  logic [Z_W-1:0]         z_p0;
  logic [IDX_W-1:0]       k_p0;
  logic [IDX_W-1:0]       l_p0;
  logic [SYM_W-1:0]       rsym_p0;
  logic [ALPHA*IDX_W-1:0] c_p0;
  logic [ALPHA*IDX_W-1:0] occk_p0;
  logic [ALPHA*IDX_W-1:0] occl_p0;

  logic [IDX_W-1:0]       c_b;
  logic [IDX_W-1:0]       occk_b;
  logic [IDX_W-1:0]       occl_b;
  logic [IDX_W:0]         kp;
  logic [IDX_W:0]         lp;
  logic                   cost;
  logic                   cand_ok;
  logic                   last;
  logic                   slot_free;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = vld_p1;

  // Candidate evaluation for symbol b_p0 against the held node
  always_comb begin
    c_b       = c_p0[b_p0*IDX_W +: IDX_W];
    occk_b    = occk_p0[b_p0*IDX_W +: IDX_W];
    occl_b    = occl_p0[b_p0*IDX_W +: IDX_W];
    kp        = {1'b0, c_b} + {1'b0, occk_b} + {{IDX_W{1'b0}}, 1'b1};
    lp        = {1'b0, c_b} + {1'b0, occl_b};
    cost      = (b_p0 != rsym_p0);
    cand_ok   = (kp <= lp) && !lp[IDX_W] && (!cost || (z_p0 != '0));
    last      = exact_p0 || (b_p0 == SYM_W'(ALPHA - 1));
    slot_free = !vld_p1 || out_ready;
  end

  // Node holding register: data only, captured on every accept
  always_ff @(posedge clk) begin
    if (in_valid && (state == IDLE)) begin
      pos_p0  <= in_pos;
      addr_p0 <= in_addr;
      i_p0    <= in_i;
      z_p0    <= in_z;
      k_p0    <= in_k;
      l_p0    <= in_l;
      rsym_p0 <= in_read_sym;
      c_p0    <= in_c;
      occk_p0 <= in_occ_k;
      occl_p0 <= in_occ_l;
    end
  end

  // Control FSM and output beat register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      b_p0      <= '0;
      exact_p0  <= 1'b0;
      vld_p1    <= 1'b0;
      prune_cnt <= '0;
      out_hit   <= 1'b0;
      out_pos   <= '0;
      out_addr  <= '0;
      out_sym   <= '0;
      out_i     <= '0;
      out_z     <= '0;
      out_k     <= '0;
      out_l     <= '0;
    end else begin
      if (vld_p1 && out_ready) vld_p1 <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_z < in_d) begin
              prune_cnt <= sat_inc16(prune_cnt);
            end else if (in_i == '0) begin
              state <= HIT;
            end else begin
              state    <= EXPAND;
              exact_p0 <= mode_exact;
              b_p0     <= mode_exact ? in_read_sym : '0;
            end
          end
        end
        EXPAND: begin
          if (!cand_ok || slot_free) begin
            if (cand_ok) begin
              vld_p1   <= 1'b1;
              out_hit  <= 1'b0;
              out_pos  <= pos_p0;
              out_addr <= addr_p0;
              out_sym  <= b_p0;
              out_i    <= i_p0 - IDX_W'(1);
              out_z    <= z_p0 - Z_W'(cost);
              out_k    <= kp[IDX_W-1:0];
              out_l    <= lp[IDX_W-1:0];
            end
            if (last) state <= IDLE;
            else      b_p0  <= b_p0 + SYM_W'(1);
          end
        end
        HIT: begin
          if (slot_free) begin
            vld_p1   <= 1'b1;
            out_hit  <= 1'b1;
            out_pos  <= pos_p0;
            out_addr <= addr_p0;
            out_sym  <= '0;
            out_i    <= i_p0;
            out_z    <= z_p0;
            out_k    <= k_p0;
            out_l    <= l_p0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_expand.sv
// Directed bench for ex_expand: child generation, pruning, hits, overflow skip,
// backpressure, mid-expansion reset and prune counter saturation.
module tb_ex_expand;
  localparam int IDX_W = 8, Z_W = 8, ADDR_W = 12, POS_W = 5, ALPHA = 4, SYM_W = 2;
  localparam logic [31:0] C0    = 32'h08050300;
  localparam logic [31:0] OK0   = 32'h00010000;
  localparam logic [31:0] OL0   = 32'h03010102;
  localparam logic [31:0] C_OV  = 32'h080503FA;
  localparam logic [31:0] OL_OV = 32'h0301010A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, mode_exact, in_valid, in_ready, out_valid, out_ready, out_hit;
  logic [POS_W-1:0] in_pos, out_pos;
  logic [ADDR_W-1:0] in_addr, out_addr;
  logic [IDX_W-1:0] in_i, in_k, in_l, out_i, out_k, out_l;
  logic [Z_W-1:0] in_z, in_d, out_z;
  logic [SYM_W-1:0] in_read_sym, out_sym;
  logic [ALPHA*IDX_W-1:0] in_c, in_occ_k, in_occ_l;
  logic [15:0] prune_cnt;

  ex_expand #(.IDX_W(IDX_W), .Z_W(Z_W), .ADDR_W(ADDR_W), .POS_W(POS_W), .ALPHA(ALPHA)) dut (
    .clk(clk), .rst(rst), .mode_exact(mode_exact), .in_valid(in_valid), .in_ready(in_ready),
    .in_pos(in_pos), .in_addr(in_addr), .in_i(in_i), .in_z(in_z), .in_d(in_d),
    .in_k(in_k), .in_l(in_l), .in_read_sym(in_read_sym), .in_c(in_c),
    .in_occ_k(in_occ_k), .in_occ_l(in_occ_l), .out_valid(out_valid), .out_ready(out_ready),
    .out_hit(out_hit), .out_pos(out_pos), .out_addr(out_addr), .out_sym(out_sym),
    .out_i(out_i), .out_z(out_z), .out_k(out_k), .out_l(out_l), .prune_cnt(prune_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
    n_cmp++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs_v, exp_v);
    end
  endtask

  function automatic logic [63:0] beat(input logic hit, input logic [1:0] sym,
                                       input logic [7:0] i, input logic [7:0] z,
                                       input logic [7:0] k, input logic [7:0] l);
    return {12'd0, 5'd9, 12'hABC, hit, sym, i, z, k, l};
  endfunction

  function automatic logic [63:0] pack_out();
    return {12'd0, out_pos, out_addr, out_hit, out_sym, out_i, out_z, out_k, out_l};
  endfunction

  always @(negedge clk) if (out_valid && out_ready) got_q.push_back(pack_out());

  task automatic send(input logic [7:0] i, input logic [7:0] z, input logic [7:0] d,
                      input logic [7:0] k, input logic [7:0] l, input logic [1:0] rs,
                      input logic ex, input logic [31:0] c, input logic [31:0] ok,
                      input logic [31:0] ol);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      check_val("send_timeout", 0, 1);
      return;
    end
    in_pos = 5'd9; in_addr = 12'hABC;
    in_i = i; in_z = z; in_d = d; in_k = k; in_l = l; in_read_sym = rs;
    mode_exact = ex; in_c = c; in_occ_k = ok; in_occ_l = ol;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (!(in_ready && !out_valid) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check_val("drain_timeout", 0, 1);
  endtask

  task automatic compare_beats(input string tag);
    check_val({tag, "_cnt"}, got_q.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++)
      check_val($sformatf("%s_b%0d", tag, j), got_q[j], exp_q[j]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mode_exact = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pos = '0; in_addr = '0; in_i = '0; in_z = '0; in_d = '0; in_k = '0; in_l = '0;
    in_read_sym = '0; in_c = '0; in_occ_k = '0; in_occ_l = '0;
    repeat (2) @(negedge clk);
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_prune", prune_cnt, 0);
    check_val("rst_fields", pack_out(), 0);
    rst = 1'b0;
    @(negedge clk);
    check_val("idle_in_ready", in_ready, 1);

    // Full expansion with latency check
    exp_q = '{beat(0, 0, 4, 0, 1, 2), beat(0, 1, 4, 1, 4, 4), beat(0, 3, 4, 0, 9, 11)};
    send(5, 1, 0, 1, 10, 1, 0, C0, OK0, OL0);
    check_val("t1_lat_T1", out_valid, 0);
    @(negedge clk);
    check_val("t1_lat_T2", out_valid, 1);
    drain();
    compare_beats("t1");

    exp_q = '{beat(0, 1, 4, 0, 4, 4)};
    send(5, 0, 0, 1, 10, 1, 0, C0, OK0, OL0);
    drain();
    compare_beats("t2_z0");

    // mode_exact flipped mid-expansion must not matter
    exp_q = '{beat(0, 1, 4, 1, 4, 4)};
    send(5, 1, 0, 1, 10, 1, 1, C0, OK0, OL0);
    mode_exact = 1'b0;
    drain();
    compare_beats("t3_exact");

    exp_q = '{beat(1, 0, 0, 2, 3, 7)};
    send(0, 2, 0, 3, 7, 0, 0, C0, OK0, OL0);
    drain();
    compare_beats("t4_hit");

    exp_q = '{beat(0, 1, 4, 1, 4, 4), beat(0, 3, 4, 0, 9, 11)};
    send(5, 1, 0, 1, 10, 1, 0, C_OV, OK0, OL_OV);
    drain();
    compare_beats("t5_ovf");

    send(5, 1, 2, 1, 10, 1, 0, C0, OK0, OL0);
    check_val("t6_prune_ready", in_ready, 1);
    check_val("t6_prune_cnt", prune_cnt, 1);
    drain();
    compare_beats("t6_prune");

    // Backpressure: first child held for 5 cycles
    out_ready = 1'b0;
    send(5, 1, 0, 1, 10, 1, 0, C0, OK0, OL0);
    @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      check_val($sformatf("t7_hold_v%0d", s), out_valid, 1);
      check_val($sformatf("t7_hold_f%0d", s), pack_out(), beat(0, 0, 4, 0, 1, 2));
      @(negedge clk);
    end
    out_ready = 1'b1;
    exp_q = '{beat(0, 0, 4, 0, 1, 2), beat(0, 1, 4, 1, 4, 4), beat(0, 3, 4, 0, 9, 11)};
    drain();
    compare_beats("t7_bp");

    // Reset mid-expansion with a stalled beat
    out_ready = 1'b0;
    send(5, 1, 0, 1, 10, 1, 0, C0, OK0, OL0);
    @(negedge clk);
    check_val("t8_pre_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check_val("t8_rst_valid", out_valid, 0);
    check_val("t8_rst_ready", in_ready, 0);
    check_val("t8_rst_prune", prune_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("t8_post_ready", in_ready, 1);
    check_val("t8_post_valid", out_valid, 0);
    out_ready = 1'b1;
    exp_q = '{};
    compare_beats("t8_dropped");

    exp_q = '{beat(0, 0, 4, 0, 1, 2), beat(0, 1, 4, 1, 4, 4), beat(0, 3, 4, 0, 9, 11)};
    @(negedge clk);
    send(5, 1, 0, 1, 10, 1, 0, C0, OK0, OL0);
    drain();
    compare_beats("t9_clean");

    // Prune counter saturation: 65535 back-to-back prunes, then one more
    in_pos = 5'd9; in_addr = 12'hABC; in_i = 8'd5; in_z = 8'd1; in_d = 8'd2;
    in_valid = 1'b1;
    repeat (65535) @(negedge clk);
    in_valid = 1'b0;
    check_val("t10_sat", prune_cnt, 16'hFFFF);
    send(5, 1, 2, 1, 10, 1, 0, C0, OK0, OL0);
    check_val("t10_sat_hold", prune_cnt, 16'hFFFF);
    drain();
    compare_beats("t10_nobeats");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
